// File: rtl/uart_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_transmitter: 8N1 UART serial transmitter, LSB first; optional even   |
// | parity bit when UART_TX_PARITY_EN is defined.      Revision: 1.0          |
// +--------------------------------------------------------------------------+
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int              c_CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    logic [2:0]      state_q, state_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif
    logic            w_last;

    assign w_last = (cnt_q == c_CNT_MAX);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        // Counter is held at zero while idle and wraps on each bit boundary,
        // which coincides with every state change.
        cnt_d = (state_q == c_IDLE || w_last) ? '0 : cnt_q + 1'b1;

        case (state_q)
            c_IDLE: begin
                if (tx_start) begin
                    state_d   = c_START;
                    shreg_d   = tx_data;
                    bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end
            c_START: begin
                if (w_last) state_d = c_DATA;
            end
            c_DATA: begin
                if (w_last) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = c_PARITY;
`else
                        state_d = c_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
                if (w_last) state_d = c_STOP;
            end
`endif
            c_STOP: begin
                if (w_last) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase

        // Line level is a function of the upcoming state so the pin is registered.
        case (state_d)
            c_START:  txd_d = 1'b0;
            c_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            c_PARITY: txd_d = parity_q;
`endif
            default:  txd_d = 1'b1;
        endcase

        busy_d = (state_d != c_IDLE);
        done_d = (state_q == c_STOP) && w_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_transmitter: self-checking bench for uart_transmitter with a      |
// | frame-level reference model.                       Revision: 1.0          |
// +--------------------------------------------------------------------------+
module tb_uart_transmitter;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int HIST = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done, uart_txd;

    uart_transmitter #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: position inside the current frame (-1 = idle).
    int          cyc = 0;
    int          pos = -1;
    logic [10:0] frame = '1;
    logic        exp_txd = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
    int          acc_cyc = -1, acc_count = 0, done_count = 0, last_done_cyc = -1;
    logic        txd_hist [0:HIST-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        exp_done = 1'b0;
        if (rst) begin
            pos = -1;
        end else if (pos < 0) begin
            if (tx_start) begin
                frame    = '1;
                frame[0] = 1'b0;
                for (int i = 0; i < 8; i++) frame[1+i] = tx_data[i];
`ifdef UART_TX_PARITY_EN
                frame[9] = ^tx_data;
`endif
                pos = 0;
                acc_cyc = cyc;
                acc_count++;
            end
        end else begin
            pos++;
            if (pos == FRAME * C) begin
                pos = -1;
                exp_done = 1'b1;
            end
        end
        exp_busy = (pos >= 0);
        exp_txd  = (pos < 0) ? 1'b1 : frame[pos / C];
        #1;
        if (cyc < HIST) txd_hist[cyc] = uart_txd;
        if (tx_done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
        end
        check("uart_txd", {31'd0, uart_txd}, {31'd0, exp_txd});
        check("tx_busy",  {31'd0, tx_busy},  {31'd0, exp_busy});
        check("tx_done",  {31'd0, tx_done},  {31'd0, exp_done});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (tx_done !== 1'b1 && k < FRAME * C + 10) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (tx_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: tx_done not seen within %0d cycles, expected a pulse", name, k);
        end
    endtask

    function automatic logic [7:0] line_byte(input int a);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = txd_hist[a + C * (1 + i) + C / 2];
        return r;
    endfunction

    logic lit_a5 [0:10];
    int   a, a1, a2, d0, q0;
    logic [3:0] lvl;

    initial begin
`ifdef UART_TX_PARITY_EN
        lit_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        lit_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
        // Reset hold for three edges.
        tick(3);
        check("rst_txd",  {31'd0, uart_txd}, 32'd1);
        check("rst_busy", {31'd0, tx_busy},  32'd0);
        check("rst_done", {31'd0, tx_done},  32'd0);
        rst = 1'b0;
        tick(2);

        // Single 8'hA5 frame against a literal line pattern.
        d0 = done_count;
        send(8'hA5);
        wait_done("a5_done");
        a = acc_cyc;
        tick(1);
        for (int b = 0; b < FRAME; b++) begin
            lvl = {txd_hist[a+4*b], txd_hist[a+4*b+1], txd_hist[a+4*b+2], txd_hist[a+4*b+3]};
            check("a5_line_bit", {28'd0, lvl}, lit_a5[b] ? 32'hF : 32'h0);
        end
        check("a5_done_latency", last_done_cyc - a, FRAME * C);
        check("a5_done_count", done_count - d0, 1);

        // Back-to-back: second request issued in the tx_done cycle.
        send(8'h00);
        wait_done("b2b_first");
        a1 = acc_cyc;
        send(8'hFF);
        a2 = acc_cyc;
        check("b2b_accept_gap", a2 - a1, FRAME * C + 1);
        check("b2b_start_bit", {31'd0, txd_hist[a2]}, 32'd0);
        wait_done("b2b_second");
        check("b2b_byte1", {24'd0, line_byte(a1)}, 32'h00);
        check("b2b_byte2", {24'd0, line_byte(a2)}, 32'hFF);

        // Request while busy is ignored and not queued.
        tick(3);
        d0 = done_count;
        q0 = acc_count;
        send(8'h3C);
        a = acc_cyc;
        tick(9);
        send(8'hFF);
        wait_done("busy_done");
        tick(FRAME * C);
        check("busy_byte", {24'd0, line_byte(a)}, 32'h3C);
        check("busy_accepts", acc_count - q0, 1);
        check("busy_dones", done_count - d0, 1);

        // Reset during data bit 3 aborts the frame.
        d0 = done_count;
        send(8'hC3);
        tick(16);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_txd",  {31'd0, uart_txd}, 32'd1);
        check("abort_busy", {31'd0, tx_busy},  32'd0);
        tick(FRAME * C + 5);
        check("abort_no_done", done_count - d0, 0);
        send(8'h55);
        a = acc_cyc;
        wait_done("post_abort");
        check("post_abort_byte", {24'd0, line_byte(a)}, 32'h55);

`ifdef UART_TX_PARITY_EN
        tick(2);
        send(8'h07);
        a = acc_cyc;
        wait_done("par07");
        check("par07_len", last_done_cyc - a, 44);
        check("par07_bit", {31'd0, txd_hist[a + 37]}, 32'd1);
        tick(1);
        send(8'h03);
        a = acc_cyc;
        wait_done("par03");
        check("par03_bit", {31'd0, txd_hist[a + 37]}, 32'd0);
`endif

        // Randomised traffic: gaps, busy-time requests and mid-frame resets.
        for (int n = 0; n < 40; n++) begin
            int mode;
            tick($urandom_range(0, 3));
            send(8'($urandom));
            mode = $urandom_range(0, 7);
            if (mode == 0) begin
                tick($urandom_range(1, 35));
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                if (mode < 4) begin
                    tick($urandom_range(1, 30));
                    tx_data  = 8'($urandom);
                    tx_start = 1'b1;
                    @(negedge clk);
                    tx_start = 1'b0;
                end
                wait_done("rand_done");
            end
        end

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
